// File: rtl/gr_rd_burst_fifo_pkg.sv
// Shared types and constants for the read burst FIFO.
// Burst length and memory bus width live here.
package gr_rd_burst_fifo_pkg;

    localparam int MEM_RD_BL = 16;
    localparam int DSIZE     = 32;
    localparam int WORD_W    = 32;
    localparam int PIX_W     = 16;

    typedef enum logic {
        REQ_IDLE = 1'b0,
        REQ_PEND = 1'b1
    } req_state_e;

endpackage

// File: rtl/gr_rd_burst_fifo_sdp_ram.sv
// Simple dual-port RAM, DEPTH x W, one write and one registered read port.
// Ports: we_i/waddr_i/wdata_i write; re_i/raddr_i read; rdata_o holds last read.
module gr_sdp_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH),
    parameter int W     = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Output register only updates on a read so the word stays put
    // while the consumer is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/gr_rd_burst_fifo.sv
// Read burst FIFO: reserves space before requesting memory bursts, stores
// 32-bit beats and serves them as 16-bit pixels (low half first) over valid/ready.
// Ports: enable_i/flush_i control; burst_req_o/burst_req_rdy_i request handshake;
// burst_wr_en_i/burst_wr_data_i memory beats; rd_vld_o/rd_rdy_i/rd_data_o pixels;
// err_rfifo_ovf sticky flag for a beat that arrived without a reservation.
module gr_rd_burst_fifo
    import gr_rd_burst_fifo_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int BL    = MEM_RD_BL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic             flush_i,
    output logic             burst_req_o,
    input  logic             burst_req_rdy_i,
    input  logic             burst_wr_en_i,
    input  logic [DSIZE-1:0] burst_wr_data_i,
    output logic             rd_vld_o,
    input  logic             rd_rdy_i,
    output logic [PIX_W-1:0] rd_data_o,
    output logic             err_rfifo_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = CW + 2;

    req_state_e state_q, state_d;

    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] resv_q, resv_d;
    logic [SW-1:0] disc_q, disc_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic          half_q, half_d;
    logic          vld_q, vld_d;
    logic          err_q, err_d;

    logic          hs, disc_hit, acc, ovf;
    logic          xfer, pop, avail, ld, fits;
    logic [CW-1:0] resv_nf;
    logic [SW-1:0] disc_nf;
    logic [WORD_W-1:0] word;

    assign hs       = (state_q == REQ_PEND) && burst_req_rdy_i;
    assign disc_hit = burst_wr_en_i && (disc_q != '0);
    assign acc      = burst_wr_en_i && !disc_hit && (resv_q != '0);
    assign ovf      = burst_wr_en_i && (disc_q == '0) && (resv_q == '0);

    assign xfer = vld_q && rd_rdy_i;
    assign pop  = xfer && half_q;

    // The word in the output register is still counted until its upper
    // half leaves, so only words beyond it are available to load.
    assign avail = count_q > CW'(vld_q);
    assign ld    = avail && (!vld_q || pop) && !flush_i;

    assign fits = ({2'b00, count_q} + {2'b00, resv_q} + SW'(BL))
                  <= SW'(DEPTH);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            REQ_IDLE: begin
                if (enable_i && !flush_i && fits) begin
                    state_d = REQ_PEND;
                end
            end
            REQ_PEND: begin
                if (burst_req_rdy_i) begin
                    state_d = REQ_IDLE;
                end
            end
            default: state_d = REQ_IDLE;
        endcase
    end

    always_comb begin
        resv_nf = resv_q + (hs ? CW'(BL) : CW'(0)) - CW'(acc);
        disc_nf = disc_q - SW'(disc_hit);

        count_d = count_q + CW'(acc) - CW'(pop);
        resv_d  = resv_nf;
        disc_d  = disc_nf;
        wptr_d  = wptr_q + AW'(acc);
        rptr_d  = rptr_q + AW'(ld);
        half_d  = xfer ? !half_q : half_q;
        vld_d   = vld_q;
        err_d   = err_q | ovf;

        if (ld) begin
            vld_d = 1'b1;
        end else if (pop) begin
            vld_d = 1'b0;
        end

        // Everything still owed by memory (including a burst granted in
        // this very cycle) must be swallowed when it eventually arrives.
        if (flush_i) begin
            count_d = '0;
            resv_d  = '0;
            disc_d  = disc_nf + SW'(resv_nf);
            wptr_d  = '0;
            rptr_d  = '0;
            half_d  = 1'b0;
            vld_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= REQ_IDLE;
            count_q <= '0;
            resv_q  <= '0;
            disc_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            half_q  <= 1'b0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            resv_q  <= resv_d;
            disc_q  <= disc_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            half_q  <= half_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    gr_sdp_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (WORD_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (acc),
        .waddr_i (wptr_q),
        .wdata_i (burst_wr_data_i[WORD_W-1:0]),
        .re_i    (ld),
        .raddr_i (rptr_q),
        .rdata_o (word)
    );

    assign burst_req_o   = (state_q == REQ_PEND);
    assign rd_vld_o      = vld_q;
    assign rd_data_o     = half_q ? word[31:16] : word[15:0];
    assign err_rfifo_ovf = err_q;

endmodule

// File: tb/tb_gr_rd_burst_fifo.sv
// Randomized bench for gr_rd_burst_fifo with a queue-based reference model.
// Memory returns granted bursts; pixels are scoreboarded in order.
module tb_gr_rd_burst_fifo;

    localparam int DEPTH = 64;
    localparam int BL    = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable_i;
    logic        flush_i;
    logic        burst_req_o;
    logic        burst_req_rdy_i;
    logic        burst_wr_en_i;
    logic [31:0] burst_wr_data_i;
    logic        rd_vld_o;
    logic        rd_rdy_i;
    logic [15:0] rd_data_o;
    logic        err_rfifo_ovf;

    gr_rd_burst_fifo #(.DEPTH(DEPTH), .BL(BL)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable_i        (enable_i),
        .flush_i         (flush_i),
        .burst_req_o     (burst_req_o),
        .burst_req_rdy_i (burst_req_rdy_i),
        .burst_wr_en_i   (burst_wr_en_i),
        .burst_wr_data_i (burst_wr_data_i),
        .rd_vld_o        (rd_vld_o),
        .rd_rdy_i        (rd_rdy_i),
        .rd_data_o       (rd_data_o),
        .err_rfifo_ovf   (err_rfifo_ovf)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] pixq[$];
    int          mem_q[$];
    int          m_resv = 0;
    int          m_disc = 0;
    bit          m_err = 0;
    int          word_ctr = 0;
    int          hs_cnt = 0;
    int          xfer_cnt = 0;
    int          cyc_n = 0;
    bit          stall_prev = 0;
    bit          flush_prev = 0;
    logic [15:0] held = '0;
    int          beat_cyc = -1;
    int          vld_cyc = -1;
    bit          cap_first = 0;
    bit          first_got = 0;
    logic [15:0] first_pix = '0;
    logic [15:0] exp_first = '0;
    int          hs0, x0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, obs, exp, cyc_n);
        end
    endtask

    function automatic int words();
        return (pixq.size() + 1) / 2;
    endfunction

    task automatic eval();
        logic [15:0] e;
        check("err", 32'(err_rfifo_ovf), 32'(m_err));
        if (flush_prev) begin
            check("vld_after_flush", 32'(rd_vld_o), 32'(0));
        end else if (stall_prev) begin
            check("hold_vld", 32'(rd_vld_o), 32'(1));
            if (rd_vld_o) check("hold_data", 32'(rd_data_o), 32'(held));
        end
        if (pixq.size() == 0) check("vld_empty", 32'(rd_vld_o), 32'(0));
        if (rd_vld_o && vld_cyc < 0) vld_cyc = cyc_n;
        if (rd_vld_o && rd_rdy_i) begin
            xfer_cnt++;
            if (pixq.size() != 0) begin
                e = pixq.pop_front();
                check("pixel", 32'(rd_data_o), 32'(e));
            end
            if (cap_first && !first_got) begin
                first_got = 1;
                first_pix = rd_data_o;
            end
        end
        if (burst_wr_en_i) begin
            if (m_disc > 0) begin
                m_disc--;
            end else if (m_resv > 0) begin
                m_resv--;
                pixq.push_back(burst_wr_data_i[15:0]);
                pixq.push_back(burst_wr_data_i[31:16]);
            end else begin
                m_err = 1;
            end
        end
        if (burst_req_o && burst_req_rdy_i) begin
            check("hs_space", 32'(words() + m_resv + BL <= DEPTH), 32'(1));
            m_resv += BL;
            mem_q.push_back(BL);
            hs_cnt++;
        end
        if (flush_i) begin
            pixq.delete();
            m_disc += m_resv;
            m_resv = 0;
        end
        stall_prev = rd_vld_o && !rd_rdy_i;
        held = rd_data_o;
        flush_prev = flush_i;
        cyc_n++;
    endtask

    task automatic step();
        @(negedge clk);
        eval();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit on, input int pct);
        burst_wr_en_i = 1'b0;
        if (on && mem_q.size() != 0 && int'($urandom_range(99)) < pct) begin
            burst_wr_en_i = 1'b1;
            burst_wr_data_i = {16'(2 * word_ctr + 2), 16'(2 * word_ctr + 1)};
            word_ctr++;
            mem_q[0] = mem_q[0] - 1;
            if (mem_q[0] == 0) void'(mem_q.pop_front());
            if (beat_cyc < 0) beat_cyc = cyc_n;
        end
    endtask

    task automatic cyc(input bit on, input int pct);
        drive(on, pct);
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        enable_i = 1'b0;
        flush_i = 1'b0;
        burst_req_rdy_i = 1'b0;
        burst_wr_en_i = 1'b0;
        burst_wr_data_i = '0;
        rd_rdy_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(burst_req_o), 32'(0));
        check("rst_vld", 32'(rd_vld_o), 32'(0));
        check("rst_data", 32'(rd_data_o), 32'(0));
        check("rst_err", 32'(err_rfifo_ovf), 32'(0));

        // 1: four back-to-back grants fill the reservation
        enable_i = 1'b1;
        burst_req_rdy_i = 1'b1;
        rd_rdy_i = 1'b1;
        rst_n = 1'b1;
        step();
        check("t1_req_cyc1", 32'(burst_req_o), 32'(1));
        repeat (12) cyc(0, 0);
        check("t1_hs", 32'(hs_cnt), 32'(4));
        check("t1_req_low", 32'(burst_req_o), 32'(0));

        // 2: first burst streams out, 2-cycle latency
        xfer_cnt = 0;
        repeat (16) cyc(1, 100);
        repeat (24) cyc(0, 0);
        check("t2_latency", 32'(vld_cyc - beat_cyc), 32'(2));
        check("t2_xfers", 32'(xfer_cnt), 32'(32));

        // 3: stall until full, then drain
        rd_rdy_i = 1'b0;
        for (int i = 0; i < 800 && words() != DEPTH; i++) cyc(1, 100);
        check("t3_full", 32'(words()), 32'(DEPTH));
        check("t3_vld", 32'(rd_vld_o), 32'(1));
        hs0 = hs_cnt;
        repeat (10) cyc(1, 100);
        check("t3_nohs", 32'(hs_cnt - hs0), 32'(0));
        check("t3_req", 32'(burst_req_o), 32'(0));
        enable_i = 1'b0;
        rd_rdy_i = 1'b1;
        x0 = xfer_cnt;
        for (int i = 0; i < 400 && pixq.size() != 0; i++) cyc(0, 0);
        repeat (3) cyc(0, 0);
        check("t3_drained", 32'(xfer_cnt - x0), 32'(2 * DEPTH));
        check("t3_vld_end", 32'(rd_vld_o), 32'(0));

        // 4: random back-pressure on both handshakes, 20 bursts
        enable_i = 1'b1;
        hs0 = hs_cnt;
        for (int i = 0; i < 6000 && hs_cnt - hs0 < 20; i++) begin
            burst_req_rdy_i = 1'($urandom_range(1));
            rd_rdy_i = 1'($urandom_range(1));
            cyc(1, 75);
        end
        check("t4_bursts", 32'(hs_cnt - hs0), 32'(20));
        enable_i = 1'b0;
        for (int i = 0; i < 4000 &&
             (mem_q.size() != 0 || pixq.size() != 0 || burst_req_o); i++) begin
            burst_req_rdy_i = 1'($urandom_range(1));
            rd_rdy_i = 1'($urandom_range(1));
            cyc(1, 75);
        end
        check("t4_drain", 32'(pixq.size() + mem_q.size()), 32'(0));
        burst_req_rdy_i = 1'b1;
        rd_rdy_i = 1'b1;
        repeat (3) cyc(0, 0);

        // 5: flush halfway through a burst
        rd_rdy_i = 1'b0;
        enable_i = 1'b1;
        hs0 = hs_cnt;
        for (int i = 0; i < 20 && hs_cnt == hs0; i++) cyc(0, 0);
        enable_i = 1'b0;
        check("t5_hs", 32'(hs_cnt - hs0), 32'(1));
        repeat (8) cyc(1, 100);
        repeat (3) cyc(0, 0);
        check("t5_vld_pre", 32'(rd_vld_o), 32'(1));
        flush_i = 1'b1;
        cyc(0, 0);
        flush_i = 1'b0;
        check("t5_vld_flush", 32'(rd_vld_o), 32'(0));
        rd_rdy_i = 1'b1;
        x0 = xfer_cnt;
        repeat (8) cyc(1, 100);
        repeat (4) cyc(0, 0);
        check("t5_dropped", 32'(xfer_cnt - x0), 32'(0));
        check("t5_vld_idle", 32'(rd_vld_o), 32'(0));
        exp_first = 16'(2 * word_ctr + 1);
        cap_first = 1;
        enable_i = 1'b1;
        hs0 = hs_cnt;
        for (int i = 0; i < 20 && hs_cnt == hs0; i++) cyc(0, 0);
        enable_i = 1'b0;
        repeat (80) cyc(1, 100);
        check("t5_first", 32'(first_pix), 32'(exp_first));
        check("t5_empty", 32'(pixq.size() + mem_q.size()), 32'(0));

        // 6: unsolicited beat
        burst_wr_en_i = 1'b1;
        burst_wr_data_i = 32'hBAD0_BAD0;
        step();
        burst_wr_en_i = 1'b0;
        repeat (3) cyc(0, 0);
        check("t6_err", 32'(err_rfifo_ovf), 32'(1));
        check("t6_vld", 32'(rd_vld_o), 32'(0));
        repeat (10) cyc(0, 0);
        check("t6_sticky", 32'(err_rfifo_ovf), 32'(1));
        rst_n = 1'b0;
        #2;
        check("t6_rst_err", 32'(err_rfifo_ovf), 32'(0));
        check("t6_rst_req", 32'(burst_req_o), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
